// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared state, frame field positions and result type for the thermocouple scanner
package tc_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, EMIT} tc_state_t;

  localparam int TC_MSB     = 31;
  localparam int TC_LSB     = 18;
  localparam int FLT_HI_BIT = 16;
  localparam int JN_MSB     = 15;
  localparam int JN_LSB     = 4;
  localparam int FLT_LO_MSB = 2;
  localparam int FLT_LO_LSB = 0;

  typedef struct packed {
    logic [13:0] tc_temp;
    logic [11:0] jn_temp;
    logic [3:0]  fault;
    logic        timeout;
  } tc_result_t;

endpackage

// File: rtl/tc_frame_decode.sv
// rtl/tc_frame_decode.sv - splits a registered 32-bit converter frame into result fields
module tc_frame_decode
  import tc_pkg::*;
(
  input  logic [31:0] i_frame,
  input  logic        i_timeout,
  output tc_result_t  o_result
);

  // Bits 17 and 3 are reserved in the converter frame.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_frame[17], i_frame[3]};

  always_comb begin
    o_result = '0;
    if (i_timeout) begin
      o_result.fault   = 4'hF;
      o_result.timeout = 1'b1;
    end else begin
      o_result.tc_temp = i_frame[TC_MSB:TC_LSB];
      o_result.jn_temp = i_frame[JN_MSB:JN_LSB];
      o_result.fault   = {i_frame[FLT_HI_BIT], i_frame[FLT_LO_MSB:FLT_LO_LSB]};
    end
  end

endmodule

// File: rtl/tc_scan_scheduler.sv
// rtl/tc_scan_scheduler.sv - periodic scan of NUM_CH converters through one shared SPI master
// Define TC_TIMEOUT_EN to enable the START/WAIT watchdog.
module tc_scan_scheduler
  import tc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SCAN_PERIOD = 1800,
  parameter int CS_SETUP    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_en_mask,
  input  logic                      spi_busy,
  input  logic [31:0]               spi_rx_data,
  output logic                      spi_ena,
  output logic [$clog2(NUM_CH)-1:0] spi_cs_sel,
  output logic                      res_valid,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [13:0]               res_tc_temp,
  output logic [11:0]               res_jn_temp,
  output logic [3:0]                res_fault,
  output logic                      res_timeout,
  output logic                      scan_overrun
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int SW = $clog2(CS_SETUP + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
`ifdef TC_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  tc_state_t         r_state;
  logic [PW-1:0]     r_period_cnt;
  logic              r_pending;
  logic              r_spi_ena;
  logic              r_res_valid;
  logic              r_timeout;
  logic              r_overrun;
  logic [NUM_CH-1:0] r_mask;
  logic [CW-1:0]     r_ch;
  logic [CW-1:0]     r_res_ch;
  logic [SW-1:0]     r_setup_cnt;
  logic [WW-1:0]     r_wd_cnt;
  logic [31:0]       r_frame;
  logic              w_wrap;
  logic              w_wd_expired;
  logic [CW:0]       w_first;
  logic [CW:0]       w_next;
  tc_result_t        w_res;

  // Returns {found, index} of the lowest set mask bit at or above start.
  function automatic logic [CW:0] find_from(input logic [NUM_CH-1:0] mask, input int start);
    logic [CW:0] hit;
    hit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i >= start && mask[i]) hit = {1'b1, CW'(i)};
    return hit;
  endfunction

  assign w_wrap       = (r_period_cnt == PW'(SCAN_PERIOD - 1));
  assign w_first      = find_from(ch_en_mask, 0);
  assign w_next       = find_from(r_mask, int'(r_ch) + 1);
  assign w_wd_expired = WD_EN && (r_wd_cnt == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !(r_state == START || r_state == WAIT)) r_wd_cnt <= '0;
    else                                               r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_period_cnt <= '0;
      r_pending    <= 1'b0;
      r_spi_ena    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_mask       <= '0;
      r_ch         <= '0;
      r_res_ch     <= '0;
      r_setup_cnt  <= '0;
      r_frame      <= '0;
    end else begin
      r_res_valid  <= 1'b0;
      r_period_cnt <= w_wrap ? '0 : r_period_cnt + 1'b1;
      case (r_state)
        IDLE: if (r_pending) begin
          r_pending <= 1'b0;
          r_mask    <= ch_en_mask;
          if (w_first[CW]) begin
            r_ch        <= w_first[CW-1:0];
            r_setup_cnt <= '0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (r_setup_cnt == SW'(CS_SETUP - 1)) begin
            r_spi_ena <= 1'b1;
            r_state   <= START;
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end
        START, WAIT: begin
          if (w_wd_expired) begin
            r_spi_ena   <= 1'b0;
            r_timeout   <= 1'b1;
            r_res_valid <= 1'b1;
            r_res_ch    <= r_ch;
            r_state     <= EMIT;
          end else if (r_state == START && spi_busy) begin
            r_spi_ena <= 1'b0;
            r_state   <= WAIT;
          end else if (r_state == WAIT && !spi_busy) begin
            r_frame     <= spi_rx_data;
            r_timeout   <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_ch    <= r_ch;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (w_next[CW]) begin
            r_ch        <= w_next[CW-1:0];
            r_setup_cnt <= '0;
            r_state     <= SETUP;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A wrap outranks the IDLE pending clear so a late scan is never lost.
      if (w_wrap) begin
        r_pending <= 1'b1;
        if (r_state != IDLE) r_overrun <= 1'b1;
      end
    end
  end

  tc_frame_decode u_decode (
    .i_frame   (r_frame),
    .i_timeout (r_timeout),
    .o_result  (w_res)
  );

  assign spi_ena      = r_spi_ena;
  assign spi_cs_sel   = r_ch;
  assign res_valid    = r_res_valid;
  assign res_ch       = r_res_ch;
  assign res_tc_temp  = w_res.tc_temp;
  assign res_jn_temp  = w_res.jn_temp;
  assign res_fault    = w_res.fault;
  assign res_timeout  = w_res.timeout;
  assign scan_overrun = r_overrun;

endmodule

// File: tb/tb_tc_scan_scheduler.sv
// tb/tb_tc_scan_scheduler.sv - directed bench for tc_scan_scheduler with a behavioural SPI master
module tb_tc_scan_scheduler;

  localparam int NUM_CH      = 4;
  localparam int SCAN_PERIOD = 1800;
  localparam int CS_SETUP    = 2;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en_mask = 4'b0000;
  logic        spi_busy = 1'b0;
  logic [31:0] spi_rx_data = '0;
  logic        spi_ena;
  logic [1:0]  spi_cs_sel;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [13:0] res_tc_temp;
  logic [11:0] res_jn_temp;
  logic [3:0]  res_fault;
  logic        res_timeout;
  logic        scan_overrun;

  tc_scan_scheduler #(
    .NUM_CH      (NUM_CH),
    .SCAN_PERIOD (SCAN_PERIOD),
    .CS_SETUP    (CS_SETUP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ch_en_mask   (ch_en_mask),
    .spi_busy     (spi_busy),
    .spi_rx_data  (spi_rx_data),
    .spi_ena      (spi_ena),
    .spi_cs_sel   (spi_cs_sel),
    .res_valid    (res_valid),
    .res_ch       (res_ch),
    .res_tc_temp  (res_tc_temp),
    .res_jn_temp  (res_jn_temp),
    .res_fault    (res_fault),
    .res_timeout  (res_timeout),
    .scan_overrun (scan_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [13:0] tc;
    logic [11:0] jn;
    logic [3:0]  flt;
    logic        to;
  } res_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   busy_len = 8;
  int   stuck_ch = -1;
  int   rem = 0;
  int   cur_ch = 0;
  int   fall_cyc = 0;
  res_t res_q[$];
  int   res_cyc_q[$];
  int   ena_cyc_q[$];
  int   min_setup = 1000;
  int   cs_stable = 0;
  int   last_lat = 0;
  logic prev_ena = 1'b0;
  logic [1:0] prev_cs = 2'd0;
  res_t mon_r;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SPI master: busy for busy_len cycles per request, frame 0x0640_1900 + channel.
  initial forever begin
    @(negedge clk);
    if (rst || (res_valid && res_timeout)) begin
      spi_busy = 1'b0;
      rem = 0;
    end else if (spi_busy) begin
      if (cur_ch != stuck_ch) begin
        rem--;
        if (rem == 0) begin
          spi_busy = 1'b0;
          spi_rx_data = 32'h0640_1900 + 32'(cur_ch);
          fall_cyc = cyc;
        end
      end
    end else if (spi_ena) begin
      spi_busy = 1'b1;
      rem = busy_len;
      cur_ch = int'(spi_cs_sel);
    end
  end

  initial forever begin
    @(negedge clk);
    cs_stable = (spi_cs_sel == prev_cs) ? cs_stable + 1 : 1;
    if (spi_ena && !prev_ena) begin
      ena_cyc_q.push_back(cyc);
      if (cs_stable - 1 < min_setup) min_setup = cs_stable - 1;
    end
    if (res_valid) begin
      mon_r = {res_ch, res_tc_temp, res_jn_temp, res_fault, res_timeout};
      res_q.push_back(mon_r);
      res_cyc_q.push_back(cyc);
      last_lat = cyc - fall_cyc;
    end
    prev_ena = spi_ena;
    prev_cs  = spi_cs_sel;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic [1:0] ch, input logic to);
    res_t r;
    if (to) r = {ch, 14'h0000, 12'h000, 4'hF, 1'b1};
    else    r = {ch, 14'h0190, 12'h190, 2'b00, ch, 1'b0};
    return r;
  endfunction

  function automatic res_t res_at(input int i);
    if (i < res_q.size()) return res_q[i];
    return '0;
  endfunction

  function automatic int ena_at(input int i);
    if (i < ena_cyc_q.size()) return ena_cyc_q[i];
    return -1;
  endfunction

  function automatic int res_cyc_at(input int i);
    if (i < res_cyc_q.size()) return res_cyc_q[i];
    return -1;
  endfunction

  task automatic clr();
    res_q.delete();
    res_cyc_q.delete();
    ena_cyc_q.delete();
    min_setup = 1000;
  endtask

  task automatic wait_res(input int n, input int budget);
    for (int i = 0; i < budget && res_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_res(input string tag, input int i, input res_t exp);
    check($sformatf("%s_%0d", tag, i), 64'(res_at(i)), 64'(exp));
  endtask

  initial begin
    int base;
    int r0;

    ch_en_mask = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({spi_ena, spi_cs_sel, res_valid, res_ch, res_tc_temp,
          res_jn_temp, res_fault, res_timeout, scan_overrun}), 64'd0);
    rst = 1'b0;
    r0 = cyc;

    // 1: all four channels, one scan per period
    wait_res(4, 2000);
    for (int i = 0; i < 4; i++) check_res("t1_res", i, mk(2'(i), 1'b0));
    check("t1_first_ena", 64'(ena_at(0) - r0), 64'd1803);
    check("t1_latency", 64'(last_lat), 64'd1);
    check("t1_overrun", 64'(scan_overrun), 64'd0);
    base = ena_at(0);
    wait_res(8, 2000);
    check("t1_period", 64'(ena_at(4) - ena_at(0)), 64'd1800);
    check("t1_ena_count", 64'(ena_cyc_q.size()), 64'd8);

    // 2: sparse mask and chip-select setup time
    ch_en_mask = 4'b1010;
    clr();
    wait_res(2, 2000);
    repeat (100) @(negedge clk);
    check("t2_res_count", 64'(res_q.size()), 64'd2);
    check_res("t2_res", 0, mk(2'd1, 1'b0));
    check_res("t2_res", 1, mk(2'd3, 1'b0));
    check("t2_ena_count", 64'(ena_cyc_q.size()), 64'd2);
    check("t2_cs_setup", 64'(min_setup), 64'd2);
    check("t2_phase", 64'((ena_at(0) - base) % 1800), 64'd0);

    // 3: empty mask stays idle, then a single channel on the next wrap
    ch_en_mask = 4'b0000;
    clr();
    repeat (5 * SCAN_PERIOD) @(negedge clk);
    check("t3_no_ena", 64'(ena_cyc_q.size()), 64'd0);
    check("t3_no_res", 64'(res_q.size()), 64'd0);
    ch_en_mask = 4'b0001;
    wait_res(1, 2000);
    repeat (100) @(negedge clk);
    check_res("t3_res", 0, mk(2'd0, 1'b0));
    check("t3_res_count", 64'(res_q.size()), 64'd1);
    check("t3_phase", 64'((ena_at(0) - base) % 1800), 64'd0);

    // 4: slow reads overrun the period; next scan follows straight after IDLE
    busy_len = 600;
    ch_en_mask = 4'b1111;
    clr();
    check("t4_overrun_before", 64'(scan_overrun), 64'd0);
    wait_res(4, 4500);
    busy_len = 8;
    check("t4_overrun", 64'(scan_overrun), 64'd1);
    for (int i = 0; i < 4; i++) check_res("t4_res", i, mk(2'(i), 1'b0));
    wait_res(8, 200);
    check("t4_restart", 64'(ena_at(4) - res_cyc_at(3)), 64'd4);
    check_res("t4_res", 4, mk(2'd0, 1'b0));

    // 6: reset while waiting on the SPI master
    clr();
    for (int i = 0; i < 2000 && ena_cyc_q.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", 64'({spi_ena, spi_cs_sel, res_valid, res_ch, res_tc_temp,
          res_jn_temp, res_fault, res_timeout, scan_overrun}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
    clr();
    wait_res(4, 2000);
    check("t6_first_ena", 64'(ena_at(0) - r0), 64'd1803);
    for (int i = 0; i < 4; i++) check_res("t6_res", i, mk(2'(i), 1'b0));

    // 5: converter on channel 2 never finishes
    stuck_ch = 2;
    clr();
`ifdef TC_TIMEOUT_EN
    wait_res(4, 2000);
    check_res("t5_res", 1, mk(2'd1, 1'b0));
    check_res("t5_res", 2, mk(2'd2, 1'b1));
    check_res("t5_res", 3, mk(2'd3, 1'b0));
    check("t5_timeout_cycles", 64'(res_cyc_at(2) - ena_at(2)), 64'd64);
`else
    wait_res(4, 2000);
    check("t5_res_count", 64'(res_q.size()), 64'd2);
    check("t5_ena_count", 64'(ena_cyc_q.size()), 64'd3);
    check("t5_ena_low", 64'(spi_ena), 64'd0);
    check("t5_timeout_flag", 64'(res_timeout), 64'd0);
`endif
    stuck_ch = -1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
